// File: rtl/count_sequencer.sv
// Run controller for the LED counter in the divided-clock domain: latches direction and limit
// on a start edge, steps led once per div_clk until the target, with pause/abort/auto-reload.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for a start rising edge; led holds (abort clears it)
// S_COUNT | stepping led toward the target once per edge
// S_PAUSE | led held while pause is high
// S_DONE  | one-cycle completion marker; reload or return to idle
module count_sequencer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0,
  parameter int RUNS_W      = 8
) (
  input  logic              div_clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic              abort,
  input  logic              dir_up,
  input  logic [WIDTH-1:0]  limit,
  output logic [WIDTH-1:0]  led,
  output logic              busy,
  output logic              done,
  output logic [RUNS_W-1:0] runs
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    led_q, led_d;
  logic [WIDTH-1:0]    lim_q, lim_d;
  logic                dir_q, dir_d;
  logic                start_q, start_d;
  logic [RUNS_W-1:0]   runs_q, runs_d;
  logic [WIDTH-1:0]    tgt;
  logic                start_rise;

  assign start_d    = start;
  assign start_rise = start & ~start_q;
  assign tgt        = dir_q ? lim_q : '0;

  always_ff @(posedge div_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      led_q   <= '0;
      lim_q   <= '0;
      dir_q   <= 1'b0;
      start_q <= 1'b0;
      runs_q  <= '0;
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      lim_q   <= lim_d;
      dir_q   <= dir_d;
      start_q <= start_d;
      runs_q  <= runs_d;
    end
  end

  // Priority everywhere: abort > pause > terminal > step.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    lim_d   = lim_q;
    dir_d   = dir_q;
    runs_d  = runs_q;
    case (state_q)
      S_IDLE: begin
        if (abort) begin
          led_d = '0;
        end else if (start_rise) begin
          dir_d   = dir_up;
          lim_d   = limit;
          led_d   = dir_up ? '0 : limit;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (abort) begin
          led_d   = '0;
          state_d = S_IDLE;
        end else if (pause) begin
          state_d = S_PAUSE;
        end else if (led_q == tgt) begin
          runs_d  = runs_q + RUNS_W'(1);
          state_d = S_DONE;
        end else begin
          led_d = dir_q ? led_q + WIDTH'(1) : led_q - WIDTH'(1);
        end
      end
      S_PAUSE: begin
        if (abort) begin
          led_d   = '0;
          state_d = S_IDLE;
        end else if (!pause) begin
          state_d = S_COUNT;
        end
      end
      S_DONE: begin
        if (abort) begin
          led_d   = '0;
          state_d = S_IDLE;
        end else if (AUTO_RELOAD) begin
          led_d   = dir_q ? '0 : lim_q;
          state_d = S_COUNT;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        led_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  assign led  = led_q;
  assign runs = runs_q;

endmodule
